// File: rtl/mul_pkg.sv
// Shared constants for the multiply functional unit: operand/tag widths and the
// default pipeline depth used by the Wallace datapath and the reservation station.
package mul_pkg;

   localparam int MUL_DATA_W = 32;
   localparam int MUL_TAG_W  = 4;
   localparam int MUL_STAGES = 3;

endpackage

// File: rtl/mul_stage_slot.sv
// One pipeline slot of the multiply controller: valid bit plus reservation-station
// tag, loaded on enable, drained when the slot advances empty, cleared by flush.
module mul_stage_slot
   import mul_pkg::*;
#(
   parameter int TAG_W = MUL_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             adv,
   input  logic             en,
   input  logic [TAG_W-1:0] tag_in,
   output logic             v,
   output logic [TAG_W-1:0] tag
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v   <= 1'b0;
         tag <= '0;
      end else begin
         if (en)
            tag <= tag_in;
         // Advancing without a load means the predecessor was empty: the slot drains.
         if (flush)
            v <= 1'b0;
         else if (en)
            v <= 1'b1;
         else if (adv)
            v <= 1'b0;
      end
   end

endmodule

// File: rtl/mul_pipe_ctrl.sv
// Pipeline controller for the Wallace-tree multiplier: registers operands, drives
// per-stage load enables, tracks tags and holds the final result until CDB grant.
module mul_pipe_ctrl
   import mul_pkg::*;
#(
   parameter int STAGES = MUL_STAGES,
   parameter int DATA_W = MUL_DATA_W,
   parameter int TAG_W  = MUL_TAG_W,
   localparam int INF_W = $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [TAG_W-1:0]  issue_tag,
   input  logic [DATA_W-1:0] issue_a,
   input  logic [DATA_W-1:0] issue_b,
   output logic [DATA_W-1:0] mul_a,
   output logic [DATA_W-1:0] mul_b,
   output logic [STAGES-1:0] stg_en,
   output logic              cdb_req,
   output logic [TAG_W-1:0]  cdb_tag,
   input  logic              cdb_grant,
   input  logic              flush,
   output logic              busy,
   output logic [INF_W-1:0]  inflight
);

   // Handshakes: issue transfers on issue_valid & issue_ready; the station holds its
   // request while ready is low. A result retires on cdb_req & cdb_grant, and grant
   // is only meaningful while cdb_req is high.

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] adv;
   logic [TAG_W-1:0]  tag_q [STAGES];
   logic              ret;
   logic              issue_fire;
   logic              all_full;
   logic [INF_W-1:0]  inflight_nxt;

   // A stage may advance when any stage at or after it is empty, or the final stage
   // retires; written as a reduction so the ripple has no combinational self-loop.
   always_comb begin
      ret      = v[STAGES-1] & cdb_grant;
      all_full = 1'b1;
      adv      = '0;
      for (int k = 0; k < STAGES; k++) begin
         all_full = 1'b1;
         for (int j = k; j < STAGES; j++)
            all_full = all_full & v[j];
         adv[k] = ~all_full | ret;
      end
   end

   assign issue_ready = adv[0] & ~flush;
   assign issue_fire  = issue_valid & issue_ready;

   genvar g;
   generate
      for (g = 0; g < STAGES; g++) begin : g_slot
         logic [TAG_W-1:0] slot_tag_in;
         if (g == 0) begin : g_head
            assign stg_en[g]   = adv[g] & issue_fire;
            assign slot_tag_in = issue_tag;
         end else begin : g_body
            assign stg_en[g]   = adv[g] & v[g-1];
            assign slot_tag_in = tag_q[g-1];
         end

         mul_stage_slot #(
            .TAG_W (TAG_W)
         ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (flush),
            .adv    (adv[g]),
            .en     (stg_en[g]),
            .tag_in (slot_tag_in),
            .v      (v[g]),
            .tag    (tag_q[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_a <= '0;
         mul_b <= '0;
      end else if (stg_en[0]) begin
         mul_a <= issue_a;
         mul_b <= issue_b;
      end
   end

   always_comb begin
      inflight_nxt = inflight + INF_W'(issue_fire) - INF_W'(ret);
      if (flush)
         inflight_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         inflight <= '0;
      else
         inflight <= inflight_nxt;
   end

   assign cdb_req = v[STAGES-1];
   assign cdb_tag = tag_q[STAGES-1];
   assign busy    = |v;

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Directed and randomized checks of mul_pipe_ctrl against a queue-of-operations
// model that tracks each in-flight op by its pipeline position.
module tb_mul_pipe_ctrl;

   localparam int S      = 3;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 4;
   localparam int IW     = $clog2(S + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              issue_valid = 1'b0;
   logic              issue_ready;
   logic [TAG_W-1:0]  issue_tag = '0;
   logic [DATA_W-1:0] issue_a = '0;
   logic [DATA_W-1:0] issue_b = '0;
   logic [DATA_W-1:0] mul_a;
   logic [DATA_W-1:0] mul_b;
   logic [S-1:0]      stg_en;
   logic              cdb_req;
   logic [TAG_W-1:0]  cdb_tag;
   logic              cdb_grant = 1'b0;
   logic              flush = 1'b0;
   logic              busy;
   logic [IW-1:0]     inflight;

   mul_pipe_ctrl #(.STAGES(S), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_tag   (issue_tag),
      .issue_a     (issue_a),
      .issue_b     (issue_b),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .stg_en      (stg_en),
      .cdb_req     (cdb_req),
      .cdb_tag     (cdb_tag),
      .cdb_grant   (cdb_grant),
      .flush       (flush),
      .busy        (busy),
      .inflight    (inflight)
   );

   // clock
   always #5 clk = ~clk;

   // model: in-flight ops oldest first, each with its stage position
   int               m_pos[$];
   logic [TAG_W-1:0] m_tag[$];
   logic [DATA_W-1:0] m_a = '0;
   logic [DATA_W-1:0] m_b = '0;
   logic [TAG_W-1:0] exp_q[$];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs at negedge, check outputs before the posedge,
   // then advance the model to the state the coming edge produces.
   task automatic step(input logic iv, input logic [TAG_W-1:0] t,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic g, input logic fl);
      int n, lim, newp;
      logic at_end, rt, acc;
      logic [S-1:0] en;
      logic [TAG_W-1:0] got;
      @(negedge clk);
      issue_valid = iv;
      issue_tag   = t;
      issue_a     = a;
      issue_b     = b;
      cdb_grant   = g;
      flush       = fl;
      #1;
      n      = m_pos.size();
      at_end = 1'b0;
      if (n > 0) at_end = (m_pos[0] == S - 1);
      rt = at_end && g;

      chk("cdb_req", 64'(cdb_req), 64'(at_end));
      if (at_end) chk("cdb_tag", 64'(cdb_tag), 64'(m_tag[0]));
      chk("busy", 64'(busy), 64'(n > 0));
      chk("inflight", 64'(inflight), 64'(n));
      chk("mul_a", 64'(mul_a), 64'(m_a));
      chk("mul_b", 64'(mul_b), 64'(m_b));

      if (rt) begin
         exp_q.push_back(m_tag[0]);
         void'(m_pos.pop_front());
         void'(m_tag.pop_front());
      end
      if (cdb_req && cdb_grant) begin
         chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            chk("sb_retire_tag", 64'(cdb_tag), 64'(got));
         end
      end

      // each op moves up as far as the op ahead of it allows
      lim = S - 1;
      en  = '0;
      for (int i = 0; i < m_pos.size(); i++) begin
         newp = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
         if (newp != m_pos[i]) en[newp] = 1'b1;
         m_pos[i] = newp;
         lim = newp - 1;
      end
      acc = !fl && iv && (lim >= 0);
      if (acc) en[0] = 1'b1;
      chk("issue_ready", 64'(issue_ready), 64'(!fl && (lim >= 0)));
      chk("stg_en", 64'(stg_en), 64'(en));

      if (fl) begin
         m_pos.delete();
         m_tag.delete();
      end else if (acc) begin
         m_pos.push_back(0);
         m_tag.push_back(t);
      end
      if (acc) begin
         m_a = a;
         m_b = b;
      end
   endtask

   task automatic idle(input logic g, input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, '0, g, 1'b0);
   endtask

   initial begin
      // reset
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      idle(1'b0, 1);

      // single op: 7 * 6 with grant held high
      step(1'b1, 4'd5, 32'd7, 32'd6, 1'b1, 1'b0);
      idle(1'b1, 1);
      chk("product", {32'b0, mul_a} * {32'b0, mul_b}, 64'd42);
      idle(1'b1, 3);

      // back-to-back tags 1..8 with continuous grant
      for (int i = 1; i <= 8; i++)
         step(1'b1, TAG_W'(i), 32'($urandom), 32'($urandom), 1'b1, 1'b0);
      idle(1'b1, 4);

      // backpressure: fill 2,3,4, tag 5 waits, then one grant cycle admits it
      for (int i = 2; i <= 4; i++)
         step(1'b1, TAG_W'(i), 32'(i), 32'(i), 1'b0, 1'b0);
      step(1'b1, 4'd5, 32'd5, 32'd5, 1'b0, 1'b0);
      step(1'b1, 4'd5, 32'd5, 32'd5, 1'b0, 1'b0);
      step(1'b1, 4'd5, 32'd5, 32'd5, 1'b1, 1'b0);
      idle(1'b1, 4);

      // bubble collapse: tag 1, gap, tag 2 with no grant
      step(1'b1, 4'd1, 32'd1, 32'd1, 1'b0, 1'b0);
      idle(1'b0, 1);
      step(1'b1, 4'd2, 32'd2, 32'd2, 1'b0, 1'b0);
      idle(1'b0, 2);
      chk("bubble_inflight", 64'(inflight), 64'd2);
      idle(1'b1, 4);

      // flush with simultaneous grant and issue
      for (int i = 6; i <= 8; i++)
         step(1'b1, TAG_W'(i), 32'(i), 32'(i), 1'b0, 1'b0);
      step(1'b1, 4'd9, 32'd9, 32'd9, 1'b1, 1'b1);
      idle(1'b1, 2);

      // asynchronous reset with three ops in flight and grant asserted
      for (int i = 10; i <= 12; i++)
         step(1'b1, TAG_W'(i), 32'(i), 32'(i), 1'b0, 1'b0);
      @(negedge clk);
      issue_valid = 1'b0;
      cdb_grant   = 1'b1;
      flush       = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_cdb_req", 64'(cdb_req), 64'd0);
      chk("rst_inflight", 64'(inflight), 64'd0);
      chk("rst_issue_ready", 64'(issue_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      m_pos.delete();
      m_tag.delete();
      m_a = '0;
      m_b = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1, 2);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), TAG_W'($urandom), 32'($urandom), 32'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      idle(1'b1, S + 2);

      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
